// File: rtl/pipelined_subtractor_64b_if.sv
// Valid/ready stream bundle for pipelined_subtractor_64b; signal names are seen from the subtractor.
// ovf_o exists only when SUB_OVERFLOW_EN is defined.
interface pipelined_subtractor_64b_if #(
  parameter int WIDTH = 64
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] op1_i;
  logic [WIDTH-1:0] op2_i;
  logic             borrow_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] diff_o;
  logic             borrow_o;
`ifdef SUB_OVERFLOW_EN
  logic             ovf_o;
`endif

  modport master (
    output valid_i, op1_i, op2_i, borrow_i, ready_i,
`ifdef SUB_OVERFLOW_EN
    input  ovf_o,
`endif
    input  ready_o, valid_o, diff_o, borrow_o
  );

  modport slave (
    input  valid_i, op1_i, op2_i, borrow_i, ready_i,
`ifdef SUB_OVERFLOW_EN
    output ovf_o,
`endif
    output ready_o, valid_o, diff_o, borrow_o
  );
endinterface

// File: rtl/pipelined_subtractor_64b.sv
// Two-stage valid/ready subtractor: diff = op1 - op2 - borrow_i, low half in stage 1, high half in stage 2.
// Optional signed-overflow output is enabled by defining SUB_OVERFLOW_EN.
module pipelined_subtractor_64b #(
  parameter int WIDTH = 64,
  parameter int SPLIT = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  pipelined_subtractor_64b_if.slave     bus
);
  localparam int HI = WIDTH - SPLIT;

  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [SPLIT-1:0] lo_q;
  logic             c_mid_q;
  logic [HI-1:0]    op1_hi_q, op2_hi_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             s2_ready, in_fire, adv, out_fire;
  logic [SPLIT:0]   lo_sum;
  logic [HI:0]      hi_sum;

  assign s2_ready    = ~s2_valid_q | bus.ready_i;
  assign bus.ready_o = ~s1_valid_q | s2_ready;
  assign in_fire     = bus.valid_i & bus.ready_o;
  assign adv         = s1_valid_q & s2_ready;
  assign out_fire    = s2_valid_q & bus.ready_i;

  // Subtraction as op1 + ~op2 + ~borrow; the carry out of each half is an inverted borrow.
  assign lo_sum = {1'b0, bus.op1_i[SPLIT-1:0]} + {1'b0, ~bus.op2_i[SPLIT-1:0]}
                + {{SPLIT{1'b0}}, ~bus.borrow_i};
  assign hi_sum = {1'b0, op1_hi_q} + {1'b0, ~op2_hi_q} + {{HI{1'b0}}, c_mid_q};

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (in_fire)  s1_valid_d = 1'b1;
    else if (adv) s1_valid_d = 1'b0;
    s2_valid_d = s2_valid_q;
    if (adv)           s2_valid_d = 1'b1;
    else if (out_fire) s2_valid_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      lo_q       <= '0;
      c_mid_q    <= 1'b0;
      op1_hi_q   <= '0;
      op2_hi_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (in_fire) begin
        lo_q     <= lo_sum[SPLIT-1:0];
        c_mid_q  <= lo_sum[SPLIT];
        op1_hi_q <= bus.op1_i[WIDTH-1:SPLIT];
        op2_hi_q <= bus.op2_i[WIDTH-1:SPLIT];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (adv) begin
        diff_q   <= {hi_sum[HI-1:0], lo_q};
        borrow_q <= ~hi_sum[HI];
      end
    end
  end

  assign bus.valid_o  = s2_valid_q;
  assign bus.diff_o   = diff_q;
  assign bus.borrow_o = borrow_q;

`ifdef SUB_OVERFLOW_EN
  logic ovf_q, ovf_d;

  // Overflow only when operand signs differ and the result sign differs from op1.
  assign ovf_d = (op1_hi_q[HI-1] ^ op2_hi_q[HI-1]) & (op1_hi_q[HI-1] ^ hi_sum[HI-1]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)  ovf_q <= 1'b0;
    else if (adv) ovf_q <= ovf_d;
  end

  assign bus.ovf_o = ovf_q;
`endif
endmodule
